// File: rtl/alu_disp_pkg.sv
// Shared types, segment constants and helpers for the sequential ALU display.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        CONV = 2'b10,
        SHOW = 2'b11
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low seven-segment code for one BCD digit, dp off.
    function automatic logic [7:0] seg_encode(input logic [3:0] bcd);
        logic [7:0] code;
        case (bcd)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Number of decimal digits needed for the largest w-bit unsigned value.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        if (w >= 64) v = '1;
        else         v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_alu_display_bcd.sv
// Sequential double-dabble binary-to-BCD converter: one load cycle, then
// IN_W shift cycles; valid rises with the last shift and holds until the
// next load.
module bcd_dd_seq #(
    parameter int IN_W  = 8,
    parameter int N_DIG = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [IN_W-1:0]      bin,
    output logic [N_DIG*4-1:0]   bcd,
    output logic                 valid
);

    localparam int SR_W = N_DIG * 4 + IN_W;
    localparam int CW   = $clog2(IN_W + 1);

    // BCD digits sit above the binary bits being shifted in.
    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_adj;
    logic [CW-1:0]   cnt_q;
    logic            valid_q;

    // Add 3 to every BCD nibble >= 5 ahead of the next shift.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < N_DIG; i++) begin
            if (sr_q[IN_W + 4*i +: 4] >= 4'd5)
                sr_adj[IN_W + 4*i +: 4] = sr_q[IN_W + 4*i +: 4] + 4'd3;
        end
    end

    // Load, then shift until the down-counter reaches its terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            sr_q    <= SR_W'(bin);
            cnt_q   <= CW'(IN_W);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            sr_q  <= sr_adj << 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                valid_q <= 1'b1;
        end
    end

    assign bcd   = sr_q[IN_W +: N_DIG*4];
    assign valid = valid_q;

endmodule

// File: rtl/seq_alu_display.sv
// Clocked mini-ALU (add/sub/iterative mul/restoring div) feeding a sequential
// BCD converter and an active-low seven-segment display formatter.
//
// state | meaning
// IDLE  | after reset, nothing shown, waiting for start
// CALC  | operands latched, arithmetic running (1 or WIDTH cycles)
// CONV  | converter loading and shifting the result magnitude
// SHOW  | result displayed, waiting for the next start
module seq_alu_display
    import alu_disp_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 6,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic [DIGITS*8-1:0]   seg,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int RES_W = 2 * WIDTH;
    localparam int NDEC  = dec_digits(RES_W);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIGITS*8-1:0] ALL_BLANK = {DIGITS{SEG_BLANK}};
    localparam logic [DIGITS*8-1:0] ALL_DASH  = {DIGITS{SEG_DASH}};

    // The sign needs one digit beyond the widest magnitude.
    if (DIGITS < NDEC + 1) begin : g_digits_check
        $error("seq_alu_display: DIGITS too small for 2*WIDTH-bit result plus sign");
    end

    state_e               state_q;
    op_e                  op_q;
    logic [RES_W-1:0]     x_q;
    logic [WIDTH-1:0]     y_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     rem_q;
    logic [RES_W-1:0]     res_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 div0_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 conv_load_q;
    logic [DIGITS*8-1:0]  disp_q;
    logic [DIGITS*8-1:0]  disp_d;
    logic [DIGITS*8-1:0]  seg_q;

    logic [NDEC*4-1:0]    conv_bcd;
    logic                 conv_valid;
    logic                 conv_finish;
    logic [DIGITS*4-1:0]  bcd_ext;
    int                   msd;

    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [WIDTH-1:0]     y_div_d;
    logic [RES_W-1:0]     mul_sum;

    bcd_dd_seq #(
        .IN_W  (RES_W),
        .N_DIG (NDEC)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (conv_load_q),
        .bin   (res_q),
        .bcd   (conv_bcd),
        .valid (conv_valid)
    );

    // One step of shift-add multiply and restoring divide.
    always_comb begin
        div_trial = {rem_q, y_q[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, b_q});
        div_sub   = div_trial[WIDTH-1:0] - b_q;
        y_div_d   = (y_q << 1) | WIDTH'(div_ge);
        mul_sum   = res_q + (y_q[0] ? x_q : '0);
    end

    // Stale valid from the previous conversion is masked during the load cycle.
    assign conv_finish = (state_q == CONV) && conv_valid && !conv_load_q;

    // Format the converted magnitude with blanking, sign and error dashes.
    always_comb begin
        bcd_ext = (DIGITS*4)'(conv_bcd);
        disp_d  = ALL_BLANK;
        msd     = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0)
                msd = i;
        end
        if (div0_q) begin
            disp_d = ALL_DASH;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (LZ_SUPPRESS == 0 || i <= msd)
                    disp_d[8*i +: 8] = seg_encode(bcd_ext[4*i +: 4]);
            end
            if (neg_q) begin
                if (LZ_SUPPRESS != 0)
                    disp_d[8*(msd+1) +: 8] = SEG_DASH;
                else
                    disp_d[8*(DIGITS-1) +: 8] = SEG_DASH;
            end
        end
    end

    // Control FSM with operand latch, arithmetic iteration and registered flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            x_q         <= '0;
            y_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            div0_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            conv_load_q <= 1'b0;
            disp_q      <= ALL_BLANK;
        end else begin
            done_q      <= 1'b0;
            conv_load_q <= 1'b0;
            case (state_q)
                IDLE, SHOW: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        x_q     <= RES_W'(a);
                        y_q     <= (op_e'(op) == OP_DIV) ? a : b;
                        b_q     <= b;
                        rem_q   <= '0;
                        res_q   <= '0;
                        neg_q   <= 1'b0;
                        div0_q  <= 1'b0;
                        err_q   <= 1'b0;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    case (op_q)
                        OP_ADD: begin
                            res_q       <= x_q + RES_W'(b_q);
                            conv_load_q <= 1'b1;
                            state_q     <= CONV;
                        end
                        OP_SUB: begin
                            if (x_q < RES_W'(b_q)) begin
                                neg_q <= 1'b1;
                                res_q <= RES_W'(b_q) - x_q;
                            end else begin
                                res_q <= x_q - RES_W'(b_q);
                            end
                            conv_load_q <= 1'b1;
                            state_q     <= CONV;
                        end
                        OP_MUL: begin
                            res_q <= mul_sum;
                            x_q   <= x_q << 1;
                            y_q   <= y_q >> 1;
                            if (cnt_q == '0) begin
                                conv_load_q <= 1'b1;
                                state_q     <= CONV;
                            end else begin
                                cnt_q <= cnt_q - CNT_W'(1);
                            end
                        end
                        default: begin
                            if (b_q == '0) begin
                                div0_q      <= 1'b1;
                                res_q       <= '0;
                                conv_load_q <= 1'b1;
                                state_q     <= CONV;
                            end else begin
                                rem_q <= div_ge ? div_sub : div_trial[WIDTH-1:0];
                                y_q   <= y_div_d;
                                if (cnt_q == '0) begin
                                    res_q       <= RES_W'(y_div_d);
                                    conv_load_q <= 1'b1;
                                    state_q     <= CONV;
                                end else begin
                                    cnt_q <= cnt_q - CNT_W'(1);
                                end
                            end
                        end
                    endcase
                end
                CONV: begin
                    if (conv_finish) begin
                        disp_q  <= disp_d;
                        err_q   <= div0_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= SHOW;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Segment pins: blanked when disabled, new value presented with done.
    always_ff @(posedge clk) begin
        if (!rst_n)
            seg_q <= ALL_BLANK;
        else if (!en)
            seg_q <= ALL_BLANK;
        else if (conv_finish)
            seg_q <= disp_d;
        else
            seg_q <= disp_q;
    end

    assign seg  = seg_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_seq_alu_display.sv
// Self-checking bench for seq_alu_display (WIDTH=4, DIGITS=6, LZ_SUPPRESS=1).
module tb_seq_alu_display;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [47:0] seg;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] BLANK6 = 48'hFFFF_FFFF_FFFF;

    seq_alu_display #(
        .WIDTH       (4),
        .DIGITS      (6),
        .LZ_SUPPRESS (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .seg   (seg),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        int          lat;
        logic [47:0] seg;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Reference: plain integer arithmetic, then decimal digits by % and /.
    function automatic logic [47:0] model_seg(input int opv, input int av, input int bv,
                                              output bit e);
        int v;
        int pos;
        bit neg;
        logic [47:0] r;
        e = 0;
        neg = 0;
        v = 0;
        case (opv)
            0: v = av + bv;
            1: begin
                if (av < bv) begin neg = 1; v = bv - av; end
                else v = av - bv;
            end
            2: v = av * bv;
            default: begin
                if (bv == 0) e = 1;
                else v = av / bv;
            end
        endcase
        if (e) return 48'hBFBF_BFBF_BFBF;
        r = BLANK6;
        pos = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 0 || v != 0) begin
                r[8*k +: 8] = enc(v % 10);
                v = v / 10;
                pos = k + 1;
            end
        end
        if (neg) r[8*pos +: 8] = 8'hBF;
        return r;
    endfunction

    // Issue one start pulse, scramble inputs afterwards, wait for done.
    task automatic run_op(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                          output int lat);
        @(posedge clk); #1;
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom);
        a = 4'($urandom);
        b = 4'($urandom);
        chk("busy_after_start", busy, 1);
        chk("err_clear_on_start", err, 0);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        int dcount;
        int first_lat;
        bit e;
        logic [47:0] exp_seg;
        int opv;
        int av;
        int bv;

        vecs[0]  = '{2'd0, 4'd9,  4'd6,  11, 48'hFFFF_FFFF_F992, 1'b0};
        vecs[1]  = '{2'd2, 4'd15, 4'd15, 14, 48'hFFFF_FFA4_A492, 1'b0};
        vecs[2]  = '{2'd1, 4'd3,  4'd7,  11, 48'hFFFF_FFFF_BF99, 1'b0};
        vecs[3]  = '{2'd3, 4'd13, 4'd4,  14, 48'hFFFF_FFFF_FFB0, 1'b0};
        vecs[4]  = '{2'd3, 4'd7,  4'd0,  0,  48'hBFBF_BFBF_BFBF, 1'b1};
        vecs[5]  = '{2'd0, 4'd1,  4'd1,  11, 48'hFFFF_FFFF_FFA4, 1'b0};
        vecs[6]  = '{2'd1, 4'd5,  4'd5,  11, 48'hFFFF_FFFF_FFC0, 1'b0};
        vecs[7]  = '{2'd2, 4'd10, 4'd10, 14, 48'hFFFF_FFF9_C0C0, 1'b0};
        vecs[8]  = '{2'd1, 4'd0,  4'd15, 11, 48'hFFFF_FFBF_F992, 1'b0};
        vecs[9]  = '{2'd3, 4'd15, 4'd1,  14, 48'hFFFF_FFFF_F992, 1'b0};
        vecs[10] = '{2'd3, 4'd3,  4'd7,  14, 48'hFFFF_FFFF_FFC0, 1'b0};
        vecs[11] = '{2'd0, 4'd15, 4'd15, 11, 48'hFFFF_FFFF_B0C0, 1'b0};

        rst_n = 1'b0; en = 1'b1; start = 1'b0; op = 2'd0; a = 4'd0; b = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_seg", seg, BLANK6);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            if (vecs[i].lat != 0) chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_seg", i), seg, vecs[i].seg);
            chk($sformatf("vec%0d_err", i), err, vecs[i].err);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            opv = int'($urandom_range(0, 3));
            av  = int'($urandom_range(0, 15));
            bv  = int'($urandom_range(0, 15));
            exp_seg = model_seg(opv, av, bv, e);
            run_op(2'(opv), 4'(av), 4'(bv), lat);
            chk($sformatf("rnd%0d_seg op=%0d a=%0d b=%0d", n, opv, av, bv), seg, exp_seg);
            chk($sformatf("rnd%0d_err", n), err, e);
            if (!e) chk($sformatf("rnd%0d_latency", n), lat, (opv <= 1) ? 11 : 14);
        end

        // start pulsed during CONV must be ignored
        @(posedge clk); #1;
        op = 2'd0; a = 4'd2; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        first_lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin start = 1'b1; op = 2'd2; a = 4'd15; b = 4'd15; end
            if (k == 4) start = 1'b0;
            if (done) begin
                dcount++;
                if (dcount == 1) first_lat = k;
            end
        end
        chk("busy_start_done_count", dcount, 1);
        chk("busy_start_latency", first_lat, 11);
        chk("busy_start_seg", seg, 48'hFFFF_FFFF_FF92);
        chk("busy_start_idle", busy, 0);

        // en gating
        en = 1'b0;
        @(posedge clk); #1;
        chk("en0_seg", seg, BLANK6);
        chk("en0_busy", busy, 0);
        en = 1'b1;
        @(posedge clk); #1;
        chk("en1_seg", seg, 48'hFFFF_FFFF_FF92);

        // Display held while computing, then reset mid-CONV
        op = 2'd0; a = 4'd9; b = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        chk("held_seg_during_conv", seg, 48'hFFFF_FFFF_FF92);
        chk("held_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_seg", seg, BLANK6);
        chk("midreset_done", done, 0);
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("midreset_no_done", dcount, 0);
        chk("midreset_seg_after", seg, BLANK6);

        run_op(2'd0, 4'd1, 4'd1, lat);
        chk("post_reset_latency", lat, 11);
        chk("post_reset_seg", seg, 48'hFFFF_FFFF_FFA4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
